neuron_seq: RTL and testbench
=============================

NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, giving the number of inputs per dot product (range 2..16).
REQ-002 The block SHALL have parameter AW, default 2, giving the weight-address width; it SHALL equal clog2(N_IN).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port w_we, input, 1 bit: weight write enable.
REQ-006 Port w_addr, input, AW bits: weight write index.
REQ-007 Port w_data, input, 8 bits signed Q1.6: weight write data.
REQ-008 Port bias, input, 8 bits signed Q1.6: bias, sampled on start.
REQ-009 Port start, input, 1 bit: begin a dot product.
REQ-010 Port x_valid, input, 1 bit: input sample valid.
REQ-011 Port x_ready, output, 1 bit: the block accepts a sample.
REQ-012 Port x_data, input, 8 bits signed Q1.6: input sample.
REQ-013 Port y_valid, output, 1 bit: result valid.
REQ-014 Port y_ready, input, 1 bit: consumer accepts the result.
REQ-015 Port y_data, output, 8 bits signed Q1.6: neuron result.
REQ-016 Port sat_flag, output, 1 bit: at least one step of this result saturated.
REQ-017 Port busy, output, 1 bit: FSM is not in IDLE.

Function
REQ-018 The block SHALL hold N_IN x 8-bit weight registers; a write occurs when w_we=1 and w_addr<N_IN, in any state, and is visible from the next cycle.
REQ-019 Writes with w_addr>=N_IN SHALL be ignored.
REQ-020 The FSM SHALL have states IDLE, ACC and DONE.
REQ-021 IDLE to ACC on start=1: acc<=bias, idx<=0, sat<=0.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 ACC: x_ready=1; on a handshake (x_valid and x_ready) acc<=step(w[idx], x_data, acc) and idx<=idx+1; idx SHALL hold when x_valid=0.
REQ-024 The handshake with idx=N_IN-1 SHALL move the FSM to DONE; x_ready SHALL be 0 in IDLE and DONE.
REQ-025 step(w,x,a), part 1: p = signed 16-bit w*x; m = {w[7]^x[7], p[12:6]}; s = 9-bit sign-extended m + sign-extended a.
REQ-026 step(w,x,a), part 2: if s[8:7]=01 the result is 0x7F; if s[8:7]=10 the result is 0x80; otherwise s[7:0]; either saturation case SHALL set sat.
REQ-027 DONE: y_valid=1, y_data=acc, sat_flag=sat, all held stable until y_ready=1, then go to IDLE next cycle.
REQ-028 start asserted in the same cycle as the DONE-exit handshake SHALL be ignored; back-to-back operation needs start in IDLE.
REQ-029 Latency: result valid on the cycle after the Nth accepted sample; minimum start-to-y_valid is N_IN+1 cycles.
REQ-030 y_data and sat_flag SHALL be 0 outside DONE.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL set the FSM to IDLE and set acc, idx, sat, all weights, x_ready, y_valid, y_data, sat_flag and busy to 0.
REQ-032 Reset SHALL take priority over start, w_we and all handshakes, including mid-ACC; the partial result SHALL be discarded.

Configuration
REQ-033 The macro NEURON_SEQ_RELU_EN, when defined, SHALL make y_data = 0 when acc[7]=1 and acc otherwise; sat_flag SHALL be unaffected.
REQ-034 When NEURON_SEQ_RELU_EN is undefined, y_data SHALL be the signed acc unchanged.

Verification
REQ-035 The bench SHALL cover: N_IN=4, all w=0x40, bias=0x10, x=0x20 x4 -> acc steps 0x30, 0x50, 0x70, then saturation; y_data=0x7F, sat_flag=1.
REQ-036 The bench SHALL cover: all w=0xC0, bias=0x00, x=0x20 x4 -> step m=0xE0 each, y_data=0x80, sat_flag=0 (exact boundary, no saturation).
REQ-037 The bench SHALL cover: x_valid toggled 1,0,0,1,1,0,1 with mixed weights -> exactly 4 samples consumed, result matches a reference model, y_valid held with y_ready=0 for 5 cycles and y_data stable.
REQ-038 The bench SHALL cover: rst pulsed after 2 accepted samples -> next cycle busy=0, y_valid=0, weights read back 0; a new start with reloaded weights gives a correct result.
REQ-039 The bench SHALL cover: w_we to idx 1 in the same cycle as the sample for idx 1 -> the old weight is used; a write to w_addr=3 for N_IN=3 -> ignored.
REQ-040 The bench SHALL cover: NEURON_SEQ_RELU_EN defined, scenario REQ-036 -> y_data=0x00, sat_flag=0.

Source files
------------

// File: rtl/neuron_seq.sv
// Sequential single neuron: bias plus N_IN weighted samples, Q1.6 saturating accumulate.
// Optional ReLU on the output when NEURON_SEQ_RELU_EN is defined.
module neuron_seq #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned AW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [7:0]    w_data,
    input  logic [7:0]    bias,
    input  logic          start,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [7:0]    x_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [7:0]    y_data,
    output logic          sat_flag,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      acc_q, acc_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            sat_q, sat_d;
    logic [7:0]      w_q [N_IN];
    logic [7:0]      w_d [N_IN];

    logic [7:0]        w_sel;
    logic signed [15:0] prod;
    logic [7:0]        m;
    logic [8:0]        s;
    logic [7:0]        step_res;
    logic              step_sat;
    logic [7:0]        y_res;
    logic              unused_prod_bits;

    // Out-of-range addresses match no entry and are dropped.
    always_comb begin
        w_d = w_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (w_we && (w_addr == AW'(i))) begin
                w_d[i] = w_data;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (idx_q == AW'(i)) begin
                w_sel = w_q[i];
            end
        end
        prod = 16'($signed(w_sel)) * 16'($signed(x_data));
        // Sign comes from operand signs, magnitude bits from the Q2.12 product.
        m    = {w_sel[7] ^ x_data[7], prod[12:6]};
        s    = {m[7], m} + {acc_q[7], acc_q};
        unique case (s[8:7])
            2'b01: begin
                step_res = 8'h7F;
                step_sat = 1'b1;
            end
            2'b10: begin
                step_res = 8'h80;
                step_sat = 1'b1;
            end
            default: begin
                step_res = s[7:0];
                step_sat = 1'b0;
            end
        endcase
    end

    assign unused_prod_bits = ^{prod[15:13], prod[5:0]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = bias;
                    idx_d   = '0;
                    sat_d   = 1'b0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (x_valid) begin
                    acc_d = step_res;
                    sat_d = sat_q | step_sat;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == AW'(N_IN - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (y_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < int'(N_IN); i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            w_q     <= w_d;
        end
    end

`ifdef NEURON_SEQ_RELU_EN
    assign y_res = acc_q[7] ? 8'h00 : acc_q;
`else
    assign y_res = acc_q;
`endif

    assign x_ready  = (state_q == StAcc);
    assign y_valid  = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign y_data   = (state_q == StDone) ? y_res : 8'h00;
    assign sat_flag = (state_q == StDone) ? sat_q : 1'b0;

endmodule

// File: tb/tb_neuron_seq.sv
// Randomized self-checking bench for neuron_seq against an integer-arithmetic neuron model.
// Honours NEURON_SEQ_RELU_EN in the model so the same bench covers both builds.
module tb_neuron_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_we, start, x_valid, y_ready;
    logic [1:0] w_addr;
    logic [7:0] w_data, bias, x_data;
    logic       x_ready, y_valid, sat_flag, busy;
    logic [7:0] y_data;

    logic       w_we3, start3, x_valid3, y_ready3;
    logic [1:0] w_addr3;
    logic [7:0] w_data3, bias3, x_data3;
    logic       x_ready3, y_valid3, sat_flag3, busy3;
    logic [7:0] y_data3;

    always #5 clk = ~clk;

    neuron_seq #(.N_IN(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .bias(bias),
        .start(start), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .sat_flag(sat_flag), .busy(busy)
    );

    neuron_seq #(.N_IN(3), .AW(2)) dut3 (
        .clk(clk), .rst(rst), .w_we(w_we3), .w_addr(w_addr3), .w_data(w_data3), .bias(bias3),
        .start(start3), .x_valid(x_valid3), .x_ready(x_ready3), .x_data(x_data3),
        .y_valid(y_valid3), .y_ready(y_ready3), .y_data(y_data3), .sat_flag(sat_flag3),
        .busy(busy3)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mw [4];
    logic [7:0] xv [4];
    int         pat [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_s(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Neuron reference: Q1.6 product truncated to 7 magnitude bits, sign = sign(w) xor sign(x),
    // then clamp the running sum to [-128, 127].
    function automatic void model(input int n, input logic [7:0] wv [4], input logic [7:0] xs [4],
                                  input logic [7:0] b, output logic [7:0] y, output logic sat);
        int a, w, x, p, mag, m, t;
        a   = to_s(b);
        sat = 1'b0;
        for (int k = 0; k < n; k++) begin
            w   = to_s(wv[k]);
            x   = to_s(xs[k]);
            p   = w * x;
            mag = (p >>> 6) & 127;
            m   = ((w < 0) != (x < 0)) ? mag - 128 : mag;
            t   = a + m;
            if (t > 127) begin
                a   = 127;
                sat = 1'b1;
            end else if (t < -128) begin
                a   = -128;
                sat = 1'b1;
            end else begin
                a = t;
            end
        end
`ifdef NEURON_SEQ_RELU_EN
        if (a < 0) a = 0;
`endif
        y = 8'(a);
    endfunction

    task automatic load_w(input int a, input logic [7:0] d);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = 2'(a);
        w_data = d;
        mw[a]  = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic load_rand_w();
        for (int i = 0; i < 4; i++) load_w(i, 8'($urandom));
    endtask

    task automatic run(input logic [7:0] b, input int hold, input bit inj, input logic [7:0] inj_v);
        logic [7:0] ey;
        logic       es;
        int         k;
        int         v;
        model(4, mw, xv, b, ey, es);
        @(negedge clk);
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        start = 1'b0;
        bias  = 8'($urandom);
        check_eq("busy_acc", 32'(busy), 32'd1);
        check_eq("y_valid_acc", 32'(y_valid), 32'd0);
        check_eq("y_data_acc", 32'(y_data), 32'd0);
        k = 0;
        while (k < 4) begin
            v       = (pat.size() > 0) ? pat.pop_front() : 1;
            x_valid = v[0];
            x_data  = v[0] ? xv[k] : 8'($urandom);
            if (inj && v[0] && k == 1) begin
                w_we   = 1'b1;
                w_addr = 2'd1;
                w_data = inj_v;
            end
            check_eq("x_ready_acc", 32'(x_ready), 32'd1);
            @(negedge clk);
            w_we = 1'b0;
            if (v[0]) k++;
        end
        x_valid = 1'b1;
        x_data  = 8'($urandom);
        check_eq("y_valid_done", 32'(y_valid), 32'd1);
        check_eq("x_ready_done", 32'(x_ready), 32'd0);
        check_eq("y_data", 32'(y_data), 32'(ey));
        check_eq("sat_flag", 32'(sat_flag), 32'(es));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("y_valid_hold", 32'(y_valid), 32'd1);
            check_eq("y_data_hold", 32'(y_data), 32'(ey));
            check_eq("sat_hold", 32'(sat_flag), 32'(es));
        end
        y_ready = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        start   = 1'b0;
        x_valid = 1'b0;
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("y_valid_idle", 32'(y_valid), 32'd0);
        check_eq("y_data_idle", 32'(y_data), 32'd0);
        check_eq("sat_idle", 32'(sat_flag), 32'd0);
        @(negedge clk);
        check_eq("start_at_exit_ignored", 32'(busy), 32'd0);
        if (inj) mw[1] = inj_v;
    endtask

    initial begin
        logic [7:0] w3 [4];
        logic [7:0] x3 [4];
        logic [7:0] ey3;
        logic       es3;
        logic [7:0] b3;

        rst = 1'b1;
        {w_we, start, x_valid, y_ready} = '0;
        w_addr = '0; w_data = '0; bias = '0; x_data = '0;
        {w_we3, start3, x_valid3, y_ready3} = '0;
        w_addr3 = '0; w_data3 = '0; bias3 = '0; x_data3 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_y_valid", 32'(y_valid), 32'd0);
        check_eq("rst_x_ready", 32'(x_ready), 32'd0);
        check_eq("rst_y_data", 32'(y_data), 32'd0);
        check_eq("rst_sat", 32'(sat_flag), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mw[i] = 8'h00;

        // Positive saturation on the last step.
        for (int i = 0; i < 4; i++) begin
            load_w(i, 8'h40);
            xv[i] = 8'h20;
        end
        run(8'h10, 2, 1'b0, 8'h00);

        // Reaches exactly -128 without saturating.
        for (int i = 0; i < 4; i++) load_w(i, 8'hC0);
        run(8'h00, 1, 1'b0, 8'h00);

        // Gapped x_valid with a long output stall.
        load_rand_w();
        for (int i = 0; i < 4; i++) xv[i] = 8'($urandom);
        pat = '{1, 0, 0, 1, 1, 0, 1};
        run(8'($urandom), 5, 1'b0, 8'h00);

        // Reset after two accepted samples discards the partial result and clears weights.
        load_rand_w();
        @(negedge clk);
        start = 1'b1;
        bias  = 8'h11;
        @(negedge clk);
        start   = 1'b0;
        x_valid = 1'b1;
        x_data  = 8'h33;
        repeat (2) @(negedge clk);
        x_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_y_valid", 32'(y_valid), 32'd0);
        check_eq("midrst_x_ready", 32'(x_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mw[i] = 8'h00;
            xv[i] = 8'($urandom);
        end
        run(8'h25, 0, 1'b0, 8'h00);
        load_rand_w();
        run(8'($urandom), 1, 1'b0, 8'h00);

        // Weight write racing the sample that reads it: old value used, new value next time.
        load_rand_w();
        for (int i = 0; i < 4; i++) xv[i] = 8'($urandom);
        run(8'($urandom), 0, 1'b1, 8'($urandom));
        run(8'($urandom), 0, 1'b0, 8'h00);

        // N_IN=3 instance: write to address 3 must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            w3[i] = 8'($urandom);
            x3[i] = 8'($urandom_range(0, 63));
        end
        w3[3] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w_we3   = 1'b1;
            w_addr3 = 2'(i);
            w_data3 = w3[i];
        end
        @(negedge clk);
        w_addr3 = 2'd3;
        w_data3 = 8'h7F;
        @(negedge clk);
        w_we3  = 1'b0;
        b3     = 8'($urandom);
        start3 = 1'b1;
        bias3  = b3;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            x_valid3 = 1'b1;
            x_data3  = x3[k];
            @(negedge clk);
        end
        x_valid3 = 1'b0;
        model(3, w3, x3, b3, ey3, es3);
        check_eq("n3_y_valid", 32'(y_valid3), 32'd1);
        check_eq("n3_y_data", 32'(y_data3), 32'(ey3));
        check_eq("n3_sat", 32'(sat_flag3), 32'(es3));
        y_ready3 = 1'b1;
        @(negedge clk);
        y_ready3 = 1'b0;
        check_eq("n3_busy_idle", 32'(busy3), 32'd0);

        // Random transactions.
        for (int t = 0; t < 15; t++) begin
            if ($urandom_range(0, 1) == 1) load_rand_w();
            for (int i = 0; i < 4; i++) xv[i] = 8'($urandom);
            pat.delete();
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) pat.push_back(int'($urandom_range(0, 1)));
            run(8'($urandom), int'($urandom_range(0, 3)), 1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
